// File: rtl/game_sequencer.sv
// Purpose : top-level Sokoban game FSM (title, instructions, stage select, map load, moves, clear, quit).
// Latency : all outputs are Moore decodes of registered state/registers; one-cycle state steps between strobes.
// Backpress: none; hold states wait for button release, draw states wait on internal frame/sprite counters.
//
// Ports:
//   clock, reset             system clock (rising edge), async active-high reset
//   start/cont/restart/quit/select/key_pressed   debounced buttons, high while held
//   stage_req[NUM_STAGES]    stage selector requests, bit i = stage i
//   char_empty/char_obs/char_box/box_empty/win   datapath feedback
//   ld_map, map_id           map load strobe and current stage
//   reset_valid, check_*, update_*, draw_*, clear_char, go_select   datapath / screen strobes
//   move_count, unlocked     moves in current stage, highest selectable stage
//   state                    current state encoding (states are numbered in declaration order)
module game_sequencer #(
    parameter int NUM_STAGES    = 8,
    parameter int STAGE_W       = 3,
    parameter int FRAME_PIXELS  = 19200,
    parameter int SPRITE_PIXELS = 64,
    parameter int MOVE_W        = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  restart,
    input  logic                  quit,
    input  logic                  select,
    input  logic                  key_pressed,
    input  logic [NUM_STAGES-1:0] stage_req,
    input  logic                  char_empty,
    input  logic                  char_obs,
    input  logic                  char_box,
    input  logic                  box_empty,
    input  logic                  win,
    output logic                  ld_map,
    output logic [STAGE_W-1:0]    map_id,
    output logic                  reset_valid,
    output logic                  check_char,
    output logic                  check_box,
    output logic                  update_char,
    output logic                  update_box,
    output logic                  draw_char,
    output logic                  draw_box,
    output logic                  clear_char,
    output logic                  draw_title,
    output logic                  draw_ins,
    output logic                  draw_clear,
    output logic                  draw_select,
    output logic                  go_select,
    output logic [MOVE_W-1:0]     move_count,
    output logic [STAGE_W-1:0]    unlocked,
    output logic [4:0]            state
);

    localparam int FRAME_W  = (FRAME_PIXELS  > 1) ? $clog2(FRAME_PIXELS)  : 1;
    localparam int SPRITE_W = (SPRITE_PIXELS > 1) ? $clog2(SPRITE_PIXELS) : 1;
    localparam logic [FRAME_W-1:0]  FRAME_LAST  = FRAME_W'(FRAME_PIXELS - 1);
    localparam logic [SPRITE_W-1:0] SPRITE_LAST = SPRITE_W'(SPRITE_PIXELS - 1);
    localparam logic [STAGE_W-1:0]  LAST_STAGE  = STAGE_W'(NUM_STAGES - 1);

    typedef enum logic [4:0] {
        TITLE, START_HOLD, DRAW_INS, INSTRUCTION, INS_HOLD, SELECT_HOLD, DRAW_SELECT,
        STAGE_SELECT, REQ_HOLD, LOAD_MAP, WAIT_MOVE, HOLD_KEY, CHECK_CHAR, CHAR_FB,
        CHECK_BOX, BOX_FB, UPDATE_BOX, DRAW_BOX, CLEAR_CHAR, UPDATE_CHAR, DRAW_CHAR,
        WIN_CHECK, DRAW_CLEAR, CLEAR, CONT_HOLD, DRAW_TITLE, RESTART_HOLD, QUIT_HOLD
    } state_t;

    state_t                state_r, state_nx;
    logic [STAGE_W-1:0]    map_id_r, map_nx;
    logic [STAGE_W-1:0]    pending_r;
    logic [STAGE_W-1:0]    unlocked_r;
    logic [MOVE_W-1:0]     move_r;
    logic [FRAME_W-1:0]    frame_cnt;
    logic [SPRITE_W-1:0]   sprite_cnt;
    logic                  frame_done, sprite_done;
    logic                  req_vld;
    logic [STAGE_W-1:0]    req_idx;

    function automatic logic is_frame(input state_t s);
        return s inside {DRAW_INS, DRAW_SELECT, LOAD_MAP, DRAW_CLEAR, DRAW_TITLE};
    endfunction

    function automatic logic is_sprite(input state_t s);
        return s inside {DRAW_BOX, CLEAR_CHAR, DRAW_CHAR};
    endfunction

    assign frame_done  = (frame_cnt == FRAME_LAST);
    assign sprite_done = (sprite_cnt == SPRITE_LAST);

    // Lowest-index request wins; anything above the unlocked stage is not selectable.
    always_comb begin
        req_vld = 1'b0;
        req_idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (stage_req[i] && (i <= int'(unlocked_r))) begin
                req_vld = 1'b1;
                req_idx = STAGE_W'(i);
            end
        end
    end

    always_comb begin
        state_nx = state_r;
        map_nx   = map_id_r;
        case (state_r)
            TITLE: begin
                if (select)     state_nx = SELECT_HOLD;
                else if (start) state_nx = START_HOLD;
            end
            START_HOLD:   if (!start) state_nx = DRAW_INS;
            DRAW_INS:     if (frame_done) state_nx = INSTRUCTION;
            INSTRUCTION:  if (start) state_nx = INS_HOLD;
            INS_HOLD: begin
                if (!start) begin
                    state_nx = LOAD_MAP;
                    map_nx   = '0;
                end
            end
            SELECT_HOLD:  if (!select) state_nx = DRAW_SELECT;
            DRAW_SELECT:  if (frame_done) state_nx = STAGE_SELECT;
            STAGE_SELECT: if (req_vld) state_nx = REQ_HOLD;
            REQ_HOLD: begin
                if (stage_req == '0) begin
                    state_nx = LOAD_MAP;
                    map_nx   = pending_r;
                end
            end
            LOAD_MAP:     if (frame_done) state_nx = WAIT_MOVE;
            WAIT_MOVE: begin
                if (restart)          state_nx = RESTART_HOLD;
                else if (key_pressed) state_nx = HOLD_KEY;
            end
            HOLD_KEY:     if (!key_pressed) state_nx = CHECK_CHAR;
            CHECK_CHAR:   state_nx = CHAR_FB;
            CHAR_FB: begin
                if (char_empty)    state_nx = CLEAR_CHAR;
                else if (char_box) state_nx = CHECK_BOX;
                else if (char_obs) state_nx = WAIT_MOVE;
                // No flag at all: treat as blocked rather than stall waiting for feedback.
                else               state_nx = WAIT_MOVE;
            end
            CHECK_BOX:    state_nx = BOX_FB;
            BOX_FB:       state_nx = box_empty ? UPDATE_BOX : WAIT_MOVE;
            UPDATE_BOX:   state_nx = DRAW_BOX;
            DRAW_BOX:     if (sprite_done) state_nx = CLEAR_CHAR;
            CLEAR_CHAR:   if (sprite_done) state_nx = UPDATE_CHAR;
            UPDATE_CHAR:  state_nx = DRAW_CHAR;
            DRAW_CHAR:    if (sprite_done) state_nx = WIN_CHECK;
            WIN_CHECK:    state_nx = win ? DRAW_CLEAR : WAIT_MOVE;
            DRAW_CLEAR:   if (frame_done) state_nx = CLEAR;
            CLEAR:        if (cont) state_nx = CONT_HOLD;
            CONT_HOLD: begin
                if (!cont) begin
                    if (map_id_r == LAST_STAGE) begin
                        state_nx = DRAW_TITLE;
                    end else begin
                        state_nx = LOAD_MAP;
                        map_nx   = map_id_r + 1'b1;
                    end
                end
            end
            DRAW_TITLE:   if (frame_done) state_nx = TITLE;
            RESTART_HOLD: if (!restart) state_nx = LOAD_MAP;
            QUIT_HOLD:    if (!quit) state_nx = DRAW_TITLE;
            default:      state_nx = TITLE;
        endcase

        // Quit overrides every transition outside the title flow.
        if (quit && !(state_r inside {TITLE, DRAW_TITLE, QUIT_HOLD})) begin
            state_nx = QUIT_HOLD;
            map_nx   = map_id_r;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= TITLE;
            map_id_r   <= '0;
            pending_r  <= '0;
            unlocked_r <= '0;
            move_r     <= '0;
            frame_cnt  <= '0;
            sprite_cnt <= '0;
        end else begin
            state_r  <= state_nx;
            map_id_r <= map_nx;

            // Counters restart on entry to a counting state and read 0 everywhere else.
            if (is_frame(state_nx) && (state_nx == state_r)) frame_cnt <= frame_cnt + 1'b1;
            else                                             frame_cnt <= '0;
            if (is_sprite(state_nx) && (state_nx == state_r)) sprite_cnt <= sprite_cnt + 1'b1;
            else                                              sprite_cnt <= '0;

            if ((state_r == STAGE_SELECT) && req_vld) pending_r <= req_idx;

            if ((state_r == WIN_CHECK) && win && (map_id_r == unlocked_r) && (unlocked_r < LAST_STAGE))
                unlocked_r <= unlocked_r + 1'b1;

            if (state_r == LOAD_MAP)
                move_r <= '0;
            else if ((state_r == UPDATE_CHAR) && (move_r != {MOVE_W{1'b1}}))
                move_r <= move_r + 1'b1;
        end
    end

    assign ld_map      = (state_r == LOAD_MAP);
    assign reset_valid = (state_r == WAIT_MOVE);
    assign check_char  = (state_r == CHECK_CHAR);
    assign check_box   = (state_r == CHECK_BOX);
    assign update_char = (state_r == UPDATE_CHAR);
    assign update_box  = (state_r == UPDATE_BOX);
    assign draw_char   = (state_r == DRAW_CHAR);
    assign draw_box    = (state_r == DRAW_BOX);
    assign clear_char  = (state_r == CLEAR_CHAR);
    assign draw_title  = (state_r == DRAW_TITLE);
    assign draw_ins    = (state_r == DRAW_INS);
    assign draw_clear  = (state_r == DRAW_CLEAR);
    assign draw_select = (state_r == DRAW_SELECT);
    assign go_select   = (state_r == STAGE_SELECT);
    assign map_id      = map_id_r;
    assign unlocked    = unlocked_r;
    assign move_count  = move_r;
    assign state       = state_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Purpose : directed self-checking bench for game_sequencer with an expected-value queue.
// Latency : checks strobe lengths, move latency and stage transitions against bench-side expectations.
// Backpress: none; every wait on the design is bounded by a cycle budget.
module tb_game_sequencer;

    localparam int NS = 8;
    localparam int SW = 3;
    localparam int FP = 320;
    localparam int SP = 64;
    localparam int MW = 10;

    localparam logic [4:0] ST_TITLE        = 5'd0;
    localparam logic [4:0] ST_INSTRUCTION  = 5'd3;
    localparam logic [4:0] ST_STAGE_SELECT = 5'd7;
    localparam logic [4:0] ST_REQ_HOLD     = 5'd8;
    localparam logic [4:0] ST_WAIT_MOVE    = 5'd10;
    localparam logic [4:0] ST_CLEAR        = 5'd23;
    localparam logic [4:0] ST_QUIT_HOLD    = 5'd27;

    localparam int S_INS = 0, S_LD = 1, S_RV = 2, S_CLR = 3, S_UCH = 4, S_DCH = 5,
                   S_CHK = 6, S_UBX = 7, S_DBX = 8, S_DCL = 9, S_DTT = 10, S_GO = 11;
    localparam int B_START = 0, B_CONT = 1, B_RESTART = 2, B_QUIT = 3, B_SELECT = 4, B_KEY = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 0, cont = 0, restart = 0, quit = 0, select = 0, key_pressed = 0;
    logic [NS-1:0] stage_req = '0;
    logic char_empty = 0, char_obs = 0, char_box = 0, box_empty = 0, win = 0;
    logic ld_map, reset_valid, check_char, check_box, update_char, update_box;
    logic draw_char, draw_box, clear_char, draw_title, draw_ins, draw_clear, draw_select, go_select;
    logic [SW-1:0] map_id, unlocked;
    logic [MW-1:0] move_count;
    logic [4:0]    state;

    always #5 clock = ~clock;

    game_sequencer #(
        .NUM_STAGES(NS), .STAGE_W(SW), .FRAME_PIXELS(FP), .SPRITE_PIXELS(SP), .MOVE_W(MW)
    ) dut (
        .clock(clock), .reset(reset),
        .start(start), .cont(cont), .restart(restart), .quit(quit), .select(select),
        .key_pressed(key_pressed), .stage_req(stage_req),
        .char_empty(char_empty), .char_obs(char_obs), .char_box(char_box),
        .box_empty(box_empty), .win(win),
        .ld_map(ld_map), .map_id(map_id), .reset_valid(reset_valid),
        .check_char(check_char), .check_box(check_box),
        .update_char(update_char), .update_box(update_box),
        .draw_char(draw_char), .draw_box(draw_box), .clear_char(clear_char),
        .draw_title(draw_title), .draw_ins(draw_ins), .draw_clear(draw_clear),
        .draw_select(draw_select), .go_select(go_select),
        .move_count(move_count), .unlocked(unlocked), .state(state)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_val(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check_val(input logic [31:0] obs);
        exp_t x;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_underflow got=%0d exp=<none>", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                bad++;
                $error("FAIL %s got=%0d exp=%0d", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] e);
        expect_val(tag, e);
        check_val(obs);
    endtask

    function automatic logic probe(input int s);
        case (s)
            S_INS:   return draw_ins;
            S_LD:    return ld_map;
            S_RV:    return reset_valid;
            S_CLR:   return clear_char;
            S_UCH:   return update_char;
            S_DCH:   return draw_char;
            S_CHK:   return check_char;
            S_UBX:   return update_box;
            S_DBX:   return draw_box;
            S_DCL:   return draw_clear;
            S_DTT:   return draw_title;
            S_GO:    return go_select;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_START:   start       = v;
            B_CONT:    cont        = v;
            B_RESTART: restart     = v;
            B_QUIT:    quit        = v;
            B_SELECT:  select      = v;
            default:   key_pressed = v;
        endcase
    endtask

    // Held for one edge, released at the following negedge.
    task automatic press(input int b);
        set_btn(b, 1'b1);
        @(negedge clock);
        set_btn(b, 1'b0);
    endtask

    task automatic wait_high(input int s, input int budget, input string tag);
        int n = 0;
        while (!probe(s) && n < budget) begin
            @(negedge clock);
            n++;
        end
        total++;
        assert (probe(s) === 1'b1) else begin
            bad++;
            $error("FAIL %s_timeout got=0 exp=1 after %0d cycles", tag, n);
        end
    endtask

    task automatic wait_state(input logic [4:0] st, input int budget, input string tag);
        int n = 0;
        while (state !== st && n < budget) begin
            @(negedge clock);
            n++;
        end
        total++;
        assert (state === st) else begin
            bad++;
            $error("FAIL %s_timeout got=%0d exp=%0d", tag, state, st);
        end
    endtask

    task automatic count_high(input int s, input int budget, output int n);
        n = 0;
        while (probe(s) && n < budget) begin
            n++;
            @(negedge clock);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_moves;
        int exp_unl;

        exp_moves = 0;
        exp_unl   = 0;
        repeat (3) @(negedge clock);
        cmp("rst_state",  32'(state),       32'(ST_TITLE));
        cmp("rst_ld_map", 32'(ld_map),      0);
        cmp("rst_map_id", 32'(map_id),      0);
        cmp("rst_unlock", 32'(unlocked),    0);
        cmp("rst_moves",  32'(move_count),  0);
        cmp("rst_rvalid", 32'(reset_valid), 0);
        reset = 1'b0;
        @(negedge clock);

        // Title -> instructions -> stage 0
        press(B_START);
        expect_val("draw_ins_len", FP);
        wait_high(S_INS, 10, "draw_ins");
        count_high(S_INS, FP + 10, n);
        check_val(32'(n));
        cmp("instr_state", 32'(state), 32'(ST_INSTRUCTION));
        press(B_START);
        expect_val("ld0_map", 0);
        expect_val("ld0_len", FP);
        wait_high(S_LD, 10, "ld0");
        check_val(32'(map_id));
        count_high(S_LD, FP + 10, n);
        check_val(32'(n));
        cmp("wait_move_rvalid", 32'(reset_valid), 1);

        // Empty-cell move: per-strobe lengths
        char_empty = 1'b1;
        press(B_KEY);
        exp_moves++;
        expect_val("clear_char_len", SP);
        expect_val("update_char", 1);
        expect_val("draw_char_len", SP);
        expect_val("moves_1", exp_moves);
        wait_high(S_CLR, 10, "clear_char");
        count_high(S_CLR, SP + 10, n);
        check_val(32'(n));
        check_val(32'(update_char));
        @(negedge clock);
        count_high(S_DCH, SP + 10, n);
        check_val(32'(n));
        wait_state(ST_WAIT_MOVE, 5, "wm_after_move");
        check_val(32'(move_count));

        // Empty-cell move: check_char to back in WAIT_MOVE
        press(B_KEY);
        exp_moves++;
        expect_val("move_latency", 2 + SP + 1 + SP + 1);
        expect_val("moves_2", exp_moves);
        wait_high(S_CHK, 5, "check_char");
        n = 0;
        while (!reset_valid && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check_val(32'(n));
        check_val(32'(move_count));

        // Blocked moves: obstacle, then no feedback at all
        char_empty = 1'b0;
        for (int k = 0; k < 2; k++) begin
            char_obs = (k == 0);
            press(B_KEY);
            expect_val($sformatf("blocked_lat_%0d", k), 3);
            expect_val($sformatf("blocked_moves_%0d", k), exp_moves);
            n = 0;
            while (!reset_valid && n < 200) begin
                @(negedge clock);
                n++;
            end
            check_val(32'(n));
            check_val(32'(move_count));
        end
        char_obs = 1'b0;

        // Box push that wins stage 0
        char_box  = 1'b1;
        box_empty = 1'b1;
        win       = 1'b1;
        press(B_KEY);
        exp_moves++;
        exp_unl = 1;
        expect_val("draw_box_len", SP);
        expect_val("draw_clear_len", FP);
        expect_val("unlock_after_0", exp_unl);
        expect_val("moves_push", exp_moves);
        wait_high(S_UBX, 10, "update_box");
        wait_high(S_DBX, 5, "draw_box");
        count_high(S_DBX, SP + 10, n);
        check_val(32'(n));
        wait_high(S_DCL, 3 * SP, "draw_clear");
        count_high(S_DCL, FP + 10, n);
        check_val(32'(n));
        wait_state(ST_CLEAR, 5, "clear0");
        check_val(32'(unlocked));
        check_val(32'(move_count));
        win       = 1'b0;
        char_box  = 1'b0;
        box_empty = 1'b0;
        press(B_CONT);
        expect_val("ld1_map", 1);
        expect_val("ld1_moves", 0);
        wait_high(S_LD, 5, "ld1");
        check_val(32'(map_id));
        @(negedge clock);
        check_val(32'(move_count));
        wait_state(ST_WAIT_MOVE, FP + 10, "wm1");

        // Quit while drawing a box
        char_box  = 1'b1;
        box_empty = 1'b1;
        press(B_KEY);
        wait_high(S_DBX, 10, "draw_box_q");
        quit = 1'b1;
        @(negedge clock);
        cmp("quit_hold", 32'(state), 32'(ST_QUIT_HOLD));
        quit      = 1'b0;
        char_box  = 1'b0;
        box_empty = 1'b0;
        wait_state(ST_TITLE, FP + 10, "title_after_quit");

        // Stage select with unlocked == 1
        press(B_SELECT);
        wait_high(S_GO, FP + 10, "go_select");
        stage_req = 8'b0000_0100;
        repeat (3) @(negedge clock);
        cmp("req_above_unlock", 32'(state), 32'(ST_STAGE_SELECT));
        stage_req = 8'b0000_0110;
        @(negedge clock);
        cmp("req_accept", 32'(state), 32'(ST_REQ_HOLD));
        stage_req = '0;
        expect_val("sel_map", 1);
        wait_high(S_LD, 5, "ld_sel");
        check_val(32'(map_id));
        wait_state(ST_WAIT_MOVE, FP + 10, "wm_sel");

        // Clear stages 1..7, restarting once on stage 3
        for (int s = 1; s < NS; s++) begin
            if (s == 3) begin
                press(B_RESTART);
                expect_val("restart_map", 3);
                wait_high(S_LD, 5, "ld_restart");
                check_val(32'(map_id));
                wait_state(ST_WAIT_MOVE, FP + 10, "wm_restart");
            end
            char_empty = 1'b1;
            win        = 1'b1;
            press(B_KEY);
            if (exp_unl == s && exp_unl < NS - 1) exp_unl++;
            expect_val($sformatf("unlock_after_%0d", s), exp_unl);
            wait_state(ST_CLEAR, 2 * SP + FP + 50, "clear_s");
            check_val(32'(unlocked));
            char_empty = 1'b0;
            win        = 1'b0;
            press(B_CONT);
            if (s < NS - 1) begin
                expect_val($sformatf("next_map_%0d", s + 1), s + 1);
                wait_high(S_LD, 5, "ld_next");
                check_val(32'(map_id));
                wait_state(ST_WAIT_MOVE, FP + 10, "wm_next");
            end else begin
                expect_val("draw_title_len", FP);
                wait_high(S_DTT, 5, "draw_title");
                count_high(S_DTT, FP + 10, n);
                check_val(32'(n));
                cmp("final_title", 32'(state), 32'(ST_TITLE));
                cmp("final_unlock", 32'(unlocked), NS - 1);
            end
        end

        // Reset in the middle of a map load
        press(B_START);
        wait_state(ST_INSTRUCTION, FP + 20, "instr2");
        press(B_START);
        wait_high(S_LD, 5, "ld_before_reset");
        repeat (5) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        cmp("async_rst_ld_map", 32'(ld_map),   0);
        cmp("async_rst_state",  32'(state),    32'(ST_TITLE));
        cmp("async_rst_unlock", 32'(unlocked), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        cmp("post_rst_state", 32'(state), 32'(ST_TITLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Parametrised top-level game FSM for the Sokoban design: title, instructions, stage select, map load, move resolution, stage clear and quit/restart flow. Replaces per-map load/hold states with a single indexed map load over `NUM_STAGES` stages, and adds stage-unlock gating, a per-stage move counter and a defined fallback for missing cell feedback. Sits between the board inputs/stage selector and the drawing datapath; all outputs are Moore decodes of the registered state or of internal registers.

## Interface
- `NUM_STAGES`, 8: number of maps; 2..2^`STAGE_W`.
- `STAGE_W`, 3: width of stage index.
- `FRAME_PIXELS`, 19200: cycles per full-screen draw/map load.
- `SPRITE_PIXELS`, 64: cycles per sprite draw/clear.
- `MOVE_W`, 10: move counter width.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces all registers to reset values.
- `start`, `cont`, `restart`, `quit`, `select`, `key_pressed` in 1 each: debounced user buttons, level-high while held.
- `stage_req` in `NUM_STAGES`: stage selector requests, bit i = stage i.
- `char_empty`, `char_obs`, `char_box`, `box_empty`, `win` in 1 each: datapath feedback.
- `ld_map` out 1: load map `map_id`, high for whole LOAD_MAP.
- `map_id` out `STAGE_W`: current stage register.
- `reset_valid`, `check_char`, `check_box`, `update_char`, `update_box`, `draw_char`, `draw_box`, `clear_char` out 1 each: datapath strobes.
- `draw_title`, `draw_ins`, `draw_clear`, `draw_select`, `go_select` out 1 each: screen/selector controls.
- `move_count` out `MOVE_W`: moves made in current stage.
- `unlocked` out `STAGE_W`: highest selectable stage index.
- `state` out 5: current state encoding (debug).

## Operation
- States: TITLE, START_HOLD, DRAW_INS, INSTRUCTION, INS_HOLD, SELECT_HOLD, DRAW_SELECT, STAGE_SELECT, REQ_HOLD, LOAD_MAP, WAIT_MOVE, HOLD_KEY, CHECK_CHAR, CHAR_FB, CHECK_BOX, BOX_FB, UPDATE_BOX, DRAW_BOX, CLEAR_CHAR, UPDATE_CHAR, DRAW_CHAR, WIN_CHECK, DRAW_CLEAR, CLEAR, CONT_HOLD, DRAW_TITLE, RESTART_HOLD, QUIT_HOLD.
- TITLE: `select` -> SELECT_HOLD (priority), else `start` -> START_HOLD. Hold states advance on button release.
- START_HOLD -> DRAW_INS -> INSTRUCTION; `start` -> INS_HOLD; release -> LOAD_MAP with stage register set to 0.
- SELECT_HOLD -> DRAW_SELECT -> STAGE_SELECT (`go_select`=1). Valid request = lowest-index set bit i of `stage_req` with i <= `unlocked`; higher bits ignored. Latch i into pending register, -> REQ_HOLD; when `stage_req`==0 -> LOAD_MAP, stage register <= pending.
- Full-screen states (DRAW_INS, DRAW_SELECT, LOAD_MAP, DRAW_CLEAR, DRAW_TITLE) exit when frame counter == `FRAME_PIXELS`-1. LOAD_MAP -> WAIT_MOVE.
- WAIT_MOVE (`reset_valid`=1): `restart` -> RESTART_HOLD (priority), else `key_pressed` -> HOLD_KEY; release -> CHECK_CHAR -> CHAR_FB.
- CHAR_FB priority: `char_empty` -> CLEAR_CHAR; `char_box` -> CHECK_BOX; otherwise (`char_obs` or no flag) -> WAIT_MOVE.
- CHECK_BOX -> BOX_FB: `box_empty` -> UPDATE_BOX -> DRAW_BOX, else WAIT_MOVE.
- Sprite states (DRAW_BOX, CLEAR_CHAR, DRAW_CHAR) exit at sprite counter == `SPRITE_PIXELS`-1: DRAW_BOX -> CLEAR_CHAR -> UPDATE_CHAR -> DRAW_CHAR -> WIN_CHECK.
- WIN_CHECK: `win`=0 -> WAIT_MOVE; `win`=1 -> DRAW_CLEAR -> CLEAR; `cont` -> CONT_HOLD; release -> LOAD_MAP(stage+1), or DRAW_TITLE -> TITLE if stage == `NUM_STAGES`-1.
- RESTART_HOLD: release -> LOAD_MAP same stage.
- `quit` high in any state except TITLE, DRAW_TITLE, QUIT_HOLD -> QUIT_HOLD next edge (overrides table); release -> DRAW_TITLE.
- Move counter: cleared every LOAD_MAP cycle; +1 in UPDATE_CHAR; saturates at all-ones.
- Unlock: in WIN_CHECK with `win`=1, if stage == `unlocked` and `unlocked` < `NUM_STAGES`-1, `unlocked` += 1. Never decreases except reset.
- Illegal state encodings -> TITLE.

## Timing
- Reset values: state TITLE, all strobes 0, `map_id` 0, `unlocked` 0, `move_count` 0, counters 0, pending 0.
- Frame/sprite counters are 0 in any non-counting state; count while in their states; each full-screen state lasts exactly `FRAME_PIXELS` cycles, each sprite state `SPRITE_PIXELS` cycles.
- Key release to `check_char`: 1 cycle after HOLD_KEY sees `key_pressed`=0. Single-cycle strobes: `check_char`, `check_box`, `update_box`, `update_char`.
- Empty-cell move: CHECK_CHAR to return to WAIT_MOVE = 2 + `SPRITE_PIXELS` + 1 + `SPRITE_PIXELS` + 1 cycles.
- `map_id` valid from first LOAD_MAP cycle; stable until next LOAD_MAP.
- Reset asserted mid-draw: outputs drop same cycle asynchronously; TITLE on release.

## Test plan
- Reset, start press/release, start press/release -> `draw_ins` high 19200 cycles, then `ld_map`=1, `map_id`=0 for 19200 cycles, then `reset_valid`=1.
- In stage 0, key on empty cell -> `clear_char` 64, `update_char` 1, `draw_char` 64 cycles, `move_count`=1; key with only `char_obs` and no flags -> WAIT_MOVE, `move_count` unchanged.
- Push with `char_box`,`box_empty`=1, then `win`=1, `cont` press/release -> `unlocked`=1, LOAD_MAP `map_id`=1, `move_count`=0.
- With `unlocked`=1, `stage_req`=8'b0000_0100 -> ignored in STAGE_SELECT; `stage_req`=8'b0000_0110 -> `map_id`=1 after release.
- Clear stage 7 (`NUM_STAGES`=8) -> `cont` release -> `draw_title` 19200 cycles -> TITLE; `unlocked` stays 7.
- `quit` during DRAW_BOX -> QUIT_HOLD next cycle; `restart` in WAIT_MOVE on stage 3 -> LOAD_MAP `map_id`=3; `reset` mid-LOAD_MAP -> `ld_map`=0 immediately.
